keypad_encoder: RTL

- Scans a 4x4 matrix keypad, debounces presses and encodes the key into the 4-bit `value` code consumed by the calculator control unit.
- Sits between the board keypad pins and the control unit's `value` input.
- Honours the control unit's `entry` flag: keys are committed only while the control unit is in an entry state.
- Runs on the control unit's slow clock domain (one clock).

---
 rtl/keypad_encoder.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/keypad_encoder.sv
// 4x4 matrix keypad scanner: rotates an active-low row strobe, debounces a
// single-key press/release, and commits the encoded key while entry is high.
module keypad_encoder #(
    parameter int SCAN_DIV = 4,
    parameter int DEBOUNCE = 3
) (
    input  logic       clock,
    input  logic       clearA,
    input  logic [3:0] col_n,
    input  logic       entry,
    output logic [3:0] row_n,
    output logic [3:0] value,
    output logic       key_valid,
    output logic       key_strobe
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_PRESSED
    } state_t;

    state_t          state, state_nxt;
    logic [1:0]      row, row_nxt;
    logic [3:0]      pat, pat_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [SW-1:0]   slot;
    logic [3:0]      value_nxt;
    logic            valid_nxt;
    logic            strobe_nxt;
    logic            tick;
    logic            single_low;
    logic            accept;

    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [3:0] c);
        logic [1:0] ci;
        logic [3:0] code;
        ci = 2'd0;
        case (c)
            4'b1101: ci = 2'd1;
            4'b1011: ci = 2'd2;
            4'b0111: ci = 2'd3;
            default: ci = 2'd0;
        endcase
        code = 4'h0;
        case ({r, ci})
            4'd0:  code = 4'h1;
            4'd1:  code = 4'h2;
            4'd2:  code = 4'h3;
            4'd3:  code = 4'hA;
            4'd4:  code = 4'h4;
            4'd5:  code = 4'h5;
            4'd6:  code = 4'h6;
            4'd7:  code = 4'hB;
            4'd8:  code = 4'h7;
            4'd9:  code = 4'h8;
            4'd10: code = 4'h9;
            4'd11: code = 4'hC;
            4'd12: code = 4'hE;
            4'd13: code = 4'h0;
            4'd14: code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    assign tick = (slot == SW'(SCAN_DIV - 1));

    always_comb begin
        case (col_n)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: single_low = 1'b1;
            default:                            single_low = 1'b0;
        endcase
    end

    always_comb row_n = ~(4'b0001 << row);

    always_comb begin
        state_nxt  = state;
        row_nxt    = row;
        pat_nxt    = pat;
        cnt_nxt    = cnt;
        value_nxt  = value;
        valid_nxt  = key_valid;
        strobe_nxt = 1'b0;
        accept     = 1'b0;
        if (tick) begin
            case (state)
                ST_SCAN: begin
                    if (single_low) begin
                        pat_nxt = col_n;
                        if (DEBOUNCE == 1) begin
                            accept = 1'b1;
                        end else begin
                            cnt_nxt   = CW'(1);
                            state_nxt = ST_DEBOUNCE;
                        end
                    end else begin
                        row_nxt = row + 2'd1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (col_n == pat) begin
                        if (int'(cnt) + 1 >= DEBOUNCE) accept = 1'b1;
                        else cnt_nxt = cnt + CW'(1);
                    end else begin
                        state_nxt = ST_SCAN;
                        row_nxt   = row + 2'd1;
                        cnt_nxt   = '0;
                    end
                end
                ST_PRESSED: begin
                    // Row stays frozen; other keys are ignored until full release.
                    if (col_n == 4'b1111) begin
                        if (int'(cnt) + 1 >= DEBOUNCE) begin
                            valid_nxt = 1'b0;
                            state_nxt = ST_SCAN;
                            row_nxt   = row + 2'd1;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt + CW'(1);
                        end
                    end else begin
                        cnt_nxt = '0;
                    end
                end
                default: state_nxt = ST_SCAN;
            endcase
        end
        // col_n equals the stored pattern on any accept tick, so it carries the column.
        if (accept) begin
            state_nxt = ST_PRESSED;
            cnt_nxt   = '0;
            if (entry) begin
                value_nxt  = key_code(row, col_n);
                strobe_nxt = 1'b1;
                valid_nxt  = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge clearA) begin
        if (!clearA) begin
            state      <= ST_SCAN;
            row        <= '0;
            pat        <= '1;
            cnt        <= '0;
            slot       <= '0;
            value      <= '0;
            key_valid  <= 1'b0;
            key_strobe <= 1'b0;
        end else begin
            state      <= state_nxt;
            row        <= row_nxt;
            pat        <= pat_nxt;
            cnt        <= cnt_nxt;
            slot       <= tick ? '0 : slot + SW'(1);
            value      <= value_nxt;
            key_valid  <= valid_nxt;
            key_strobe <= strobe_nxt;
        end
    end

endmodule
